decoder_3b_5b_stream: RTL and testbench

DECODER_3B_5B_STREAM -- requirements
Module: decoder_3b_5b_stream

---
 rtl/decoder_3b_5b_stream_pkg.sv | 30 +++
 rtl/decoder_3b_5b_stream_skid_buf_2.sv | 79 +++++++
 rtl/decoder_3b_5b_stream.sv | 68 ++++++
 tb/tb_decoder_3b_5b_stream.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_3b_5b_stream_pkg.sv
// Shared widths, constants and types for the 3-bit to 5-bit one-hot stream decoder.
// Optional illegal-code counter is enabled with the DECODER_ERR_CNT_EN macro.
package decoder_3b_5b_stream_pkg;

  localparam int CODE_W    = 3;
  localparam int ONEHOT_W  = 5;
  localparam int DATA_W    = ONEHOT_W + 1;
  localparam int ERR_CNT_W = 8;

  localparam logic [CODE_W-1:0]    MAX_CODE    = 3'd4;
  localparam logic [ONEHOT_W-1:0]  ILLEGAL_OUT = 5'b00000;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'hFF;

  // One buffered result: the decoded word plus its illegal-code flag.
  typedef struct packed {
    logic [ONEHOT_W-1:0] word;
    logic                err;
  } dec_word_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  function automatic logic is_illegal(input logic [CODE_W-1:0] code);
    return code > MAX_CODE;
  endfunction

endpackage

// File: rtl/decoder_3b_5b_stream_skid_buf_2.sv
// Two-entry in-order result buffer with registered ready/valid handshakes.
// Ready depends only on stored occupancy, never combinationally on out_ready.
module skid_buf_2
  import decoder_3b_5b_stream_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  occ_t              r_occ;
  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;
  logic              r_in_ready;
  logic              r_out_valid;

  logic w_push;
  logic w_pop;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = r_out_valid & out_ready;

  // r_head always holds the oldest entry; r_tail is only meaningful when full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ       <= OCC_EMPTY;
      r_head      <= '0;
      r_tail      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_occ)
        OCC_EMPTY: begin
          if (w_push) begin
            r_head      <= in_data;
            r_occ       <= OCC_ONE;
            r_out_valid <= 1'b1;
          end
        end
        OCC_ONE: begin
          if (w_push && w_pop) begin
            r_head <= in_data;
          end else if (w_push) begin
            r_tail     <= in_data;
            r_occ      <= OCC_FULL;
            r_in_ready <= 1'b0;
          end else if (w_pop) begin
            r_head      <= '0;
            r_occ       <= OCC_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        OCC_FULL: begin
          if (w_pop) begin
            r_head     <= r_tail;
            r_occ      <= OCC_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_occ       <= OCC_EMPTY;
          r_head      <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_head;

endmodule

// File: rtl/decoder_3b_5b_stream.sv
// Streaming 3-bit binary to 5-bit one-hot decoder with a 2-entry output buffer.
// Define DECODER_ERR_CNT_EN to add the saturating illegal-code counter err_cnt.
module decoder_3b_5b_stream
  import decoder_3b_5b_stream_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CODE_W-1:0]   in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ONEHOT_W-1:0] out,
  output logic                out_err
`ifdef DECODER_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  logic [ONEHOT_W-1:0] w_onehot;
  logic                w_err;
  dec_word_t           w_dec;
  dec_word_t           w_buf_out;
  logic                w_buf_in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < ONEHOT_W; gi++) begin : g_onehot
      assign w_onehot[gi] = (in == CODE_W'(gi));
    end
  endgenerate

  assign w_err      = is_illegal(in);
  assign w_dec.word = w_err ? ILLEGAL_OUT : w_onehot;
  assign w_dec.err  = w_err;

  skid_buf_2 u_skid_buf_2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (w_buf_in_ready),
    .in_data   (w_dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_buf_out)
  );

  assign in_ready = w_buf_in_ready;
  assign out      = w_buf_out.word;
  assign out_err  = w_buf_out.err;

`ifdef DECODER_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // Counts illegal codes at acceptance, so held-off codes are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (in_valid && w_buf_in_ready && w_err && (r_err_cnt != ERR_CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_decoder_3b_5b_stream.sv
// Randomised and directed bench for decoder_3b_5b_stream against a queue-based model.
// Build with DECODER_ERR_CNT_EN defined to also check the illegal-code counter.
module tb_decoder_3b_5b_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] in_code = 3'd0;
  logic       in_ready;
  logic       out_valid;
  logic [4:0] out_word;
  logic       out_err;
`ifdef DECODER_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  decoder_3b_5b_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_word),
    .out_err   (out_err)
`ifdef DECODER_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [4:0] mq_out[$];
  logic       mq_err[$];
  int         m_cnt = 0;
  bit         model_ok = 0;

  logic [4:0] log_out[$];
  logic       log_err[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_word(input int code);
    if (code <= 4) return 5'(1 << code);
    return 5'd0;
  endfunction

  // Reference model: a FIFO of at most two decoded words.
  always @(posedge clk) begin
    if (rst) begin
      mq_out.delete();
      mq_err.delete();
      m_cnt    = 0;
      model_ok = 1;
    end else if (model_ok) begin
      bit push;
      bit pop;
      push = in_valid && (mq_out.size() < 2);
      pop  = (mq_out.size() > 0) && out_ready;
      if (pop) begin
        void'(mq_out.pop_front());
        void'(mq_err.pop_front());
      end
      if (push) begin
        mq_out.push_back(ref_word(int'(in_code)));
        mq_err.push_back(in_code > 3'd4);
        if (in_code > 3'd4 && m_cnt < 255) m_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, mq_out.size() < 2});
      chk("out_valid", {31'd0, out_valid}, {31'd0, mq_out.size() > 0});
      if (mq_out.size() > 0) begin
        chk("out", {27'd0, out_word}, {27'd0, mq_out[0]});
        chk("out_err", {31'd0, out_err}, {31'd0, mq_err[0]});
      end
`ifdef DECODER_ERR_CNT_EN
      chk("err_cnt", {24'd0, err_cnt}, m_cnt);
`endif
      if (out_valid && out_ready && !rst) begin
        log_out.push_back(out_word);
        log_err.push_back(out_err);
        $display("xfer out=%b err=%b t=%0t", out_word, out_err, $time);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    log_out.delete();
    log_err.delete();
  endtask

  logic [4:0] exp30[8];
  int         sent[$];

  initial begin
    exp30 = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00000, 5'b00000, 5'b00000};

    // Reset state
    do_reset();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out", {27'd0, out_word}, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);

    // Single code, latency 1
    out_ready = 1'b1;
    in_code   = 3'd3;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat1_out", {27'd0, out_word}, 32'b01000);
    chk("lat1_valid", {31'd0, out_valid}, 32'd1);
    chk("lat1_err", {31'd0, out_err}, 32'd0);
    step();
    chk("lat1_drained", {31'd0, out_valid}, 32'd0);
    chk("lat1_count", log_out.size(), 32'd1);

    // Back-to-back stream of every code
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_code  = 3'(c);
      in_valid = 1'b1;
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    chk("stream_count", log_out.size(), 32'd8);
    for (int i = 0; i < 8 && i < log_out.size(); i++) begin
      chk("stream_word", {27'd0, log_out[i]}, {27'd0, exp30[i]});
      chk("stream_err", {31'd0, log_err[i]}, (i >= 5) ? 32'd1 : 32'd0);
    end

    // Back-pressure: two accepted, third held off
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 3'd1;
    step();
    in_code = 3'd2;
    chk("bp_ready_one", {31'd0, in_ready}, 32'd1);
    step();
    chk("bp_ready_full", {31'd0, in_ready}, 32'd0);
    in_code = 3'd4;
    step();
    step();
    chk("bp_still_full", {31'd0, in_ready}, 32'd0);
    chk("bp_head_stable", {27'd0, out_word}, 32'b00010);
    chk("bp_no_xfer", log_out.size(), 32'd0);
    out_ready = 1'b1;
    step();
    chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("bp_count", log_out.size(), 32'd3);
    if (log_out.size() == 3) begin
      chk("bp_w0", {27'd0, log_out[0]}, 32'b00010);
      chk("bp_w1", {27'd0, log_out[1]}, 32'b00100);
      chk("bp_w2", {27'd0, log_out[2]}, 32'b10000);
    end

    // Simultaneous push and pop at occupancy 1
    do_reset();
    sent.delete();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 3'($urandom_range(0, 7));
    sent.push_back(int'(in_code));
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_code = 3'($urandom_range(0, 7));
      sent.push_back(int'(in_code));
      step();
      chk("flow_in_ready", {31'd0, in_ready}, 32'd1);
      chk("flow_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    step();
    chk("flow_count", log_out.size(), 32'd11);
    for (int i = 0; i < 11 && i < log_out.size(); i++) begin
      chk("flow_order", {27'd0, log_out[i]}, {27'd0, ref_word(sent[i])});
    end

    // Reset with a full buffer
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 3'd0;
    step();
    step();
    in_valid = 1'b0;
    chk("full_before_rst", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_flush_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_flush_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    step();
    step();
    chk("rst_no_stale", log_out.size(), 32'd0);

    // Randomised traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_code   = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rst      = 1'b0;
    in_valid = 1'b0;

`ifdef DECODER_ERR_CNT_EN
    // Counter saturation and clear
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_code   = 3'd6;
    repeat (10) step();
    chk("errcnt_10", {24'd0, err_cnt}, 32'd10);
    repeat (290) step();
    chk("errcnt_sat", {24'd0, err_cnt}, 32'hFF);
    repeat (5) step();
    chk("errcnt_hold", {24'd0, err_cnt}, 32'hFF);
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    chk("errcnt_clear", {24'd0, err_cnt}, 32'd0);
`endif

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
